// File: rtl/fetch_prefetch_unit.sv
// RV32 fetch stage: pipelined imem requests feeding a show-ahead prefetch FIFO.
// Optional macro FETCH_BYPASS_EN: when the FIFO is empty, a fresh response goes straight to decode.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          grant, rv, accept, push, pop, fifo_nempty;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];
  assign fifo_nempty    = (cnt_q != '0);

  assign imem_req_o  = !rst_i && !redirect_i && (outst_q < MAXO_C) &&
                       ((CW+1)'(outst_q) + (CW+1)'(cnt_q) < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
  assign rv          = imem_rvalid_i && (outst_q != '0);
  assign accept      = rv && !redirect_i && (discard_q == '0);
  assign pop         = fifo_nempty && !stall_i;

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp        = accept && !fifo_nempty;
  assign push       = accept && !(byp && !stall_i);
  assign if_valid_o = fifo_nempty || byp;
  assign if_pc_o    = fifo_nempty ? mem_q[rd_ptr_q].pc    : resp_pc_q;
  assign if_instr_o = fifo_nempty ? mem_q[rd_ptr_q].instr : imem_rdata_i;
`else
  assign push       = accept;
  assign if_valid_o = fifo_nempty;
  assign if_pc_o    = mem_q[rd_ptr_q].pc;
  assign if_instr_o = mem_q[rd_ptr_q].instr;
`endif

  always_comb begin
    mem_d      = mem_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    outst_d    = outst_q + CW'(grant) - CW'(rv);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rv && discard_q != '0) discard_d = discard_q - 1'b1;
    if (accept) resp_pc_d = resp_pc_q + 32'd4;
    if (push) begin
      mem_d[wr_ptr_q] = '{pc: resp_pc_q, instr: imem_rdata_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Everything already granted is stale: drop exactly that many responses.
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
      discard_d  = outst_d;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q      <= '{default: '0};
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Issue credit accounts for every in-flight word, so a full FIFO never sees a lone push.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && cnt_q == DEPTH_C));

endmodule
